adc_capture_stream: RTL and testbench

Parametrised multi-channel ADC capture front end. On a trigger it grabs a programmed number of sample frames (one frame = all channels in one clock) and packs each channel into its own lane. It buffers the frames in a small FIFO and emits them on an AXI4-Stream master with full tready backpressure, tlast on the final frame, and sticky overflow reporting. It sits between the ADC pins/deserialiser and the DMA stream path, and supports single-shot and continuous modes.

---
 rtl/adc_capture_pkg.sv | 31 +++
 rtl/adc_capture_fifo.sv | 55 +++++
 rtl/adc_capture_stream.sv | 146 ++++++++++++++
 tb/tb_adc_capture_stream.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_capture_pkg.sv
// rtl/adc_capture_pkg.sv - shared state encoding and lane packing helper for adc_capture_stream
package adc_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DRAIN   = 2'd2
    } state_t;

    localparam logic [1:0] STATE_IDLE    = 2'd0;
    localparam logic [1:0] STATE_CAPTURE = 2'd1;
    localparam logic [1:0] STATE_DRAIN   = 2'd2;

    // Widest lane the helper can build; callers truncate to their LANE_W.
    localparam int MAX_LANE_W = 256;

    // Extends the low adc_w bits of sample to a full lane, either by
    // replicating the sample MSB (sign = 1) or by zero padding.
    function automatic logic [MAX_LANE_W-1:0] lane_pack(
        input logic [MAX_LANE_W-1:0] sample,
        input int                    adc_w,
        input logic                  sign
    );
        logic [MAX_LANE_W-1:0] mask;
        logic [MAX_LANE_W-1:0] msb_vec;
        mask    = ~({MAX_LANE_W{1'b1}} << adc_w);
        msb_vec = sample >> (adc_w - 1);
        lane_pack = (sample & mask) | ((sign && msb_vec[0]) ? ~mask : '0);
    endfunction

endpackage

// File: rtl/adc_capture_fifo.sv
// rtl/adc_capture_fifo.sv - synchronous first-word-fall-through frame FIFO
// Ports: aclk/areset (sync, active high), push/push_data write side,
// pop/pop_data read side (head visible while !empty), full/empty status.
// A push while full is accepted only when a pop happens in the same cycle.
module adc_capture_fifo #(
    parameter int WIDTH = 129,
    parameter int DEPTH = 16
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             wr_en;
    logic             rd_en;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);

    // Head is forced to zero when empty so the stream never shows stale data.
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, rd_en})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (wr_en) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/adc_capture_stream.sv
// rtl/adc_capture_stream.sv - triggered multi-channel ADC capture to AXI4-Stream
// Ports: aclk/areset (sync, active high); control sample_count, start_trigger,
// continuous, abort; status start_trigger_ack, done, sample_counter,
// sample_state, overflow; adc_data input frame; m_axis_* stream master.
// Optional macro ADC_CAPTURE_DECIM_EN adds decim: capture every decim+1 cycles.
module adc_capture_stream
    import adc_capture_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int ADC_W      = 14,
    parameter int LANE_W     = 64,
    parameter int CNT_W      = 32,
    parameter int FIFO_DEPTH = 16,
    parameter int SIGN_EXT   = 1
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic [CNT_W-1:0]         sample_count,
    input  logic                     start_trigger,
    input  logic                     continuous,
    input  logic                     abort,
`ifdef ADC_CAPTURE_DECIM_EN
    input  logic [7:0]               decim,
`endif
    output logic                     start_trigger_ack,
    output logic                     done,
    output logic [CNT_W-1:0]         sample_counter,
    output logic [1:0]               sample_state,
    output logic                     overflow,
    input  logic [NUM_CH*ADC_W-1:0]  adc_data,
    output logic [NUM_CH*LANE_W-1:0] m_axis_tdata,
    output logic                     m_axis_tvalid,
    output logic                     m_axis_tlast,
    input  logic                     m_axis_tready
);
    state_t                   state, state_nxt;
    logic [CNT_W-1:0]         cnt_nxt;
    logic                     ack_nxt, done_nxt, ovf_nxt;
    logic                     cap_en, fire, push, drop, pop;
    logic                     fifo_full, fifo_empty;
    logic [NUM_CH*LANE_W-1:0] frame_data;
    logic [NUM_CH*LANE_W:0]   fifo_out;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
        assign frame_data[k*LANE_W +: LANE_W] = LANE_W'(lane_pack(
            MAX_LANE_W'(adc_data[k*ADC_W +: ADC_W]), ADC_W, SIGN_EXT != 0));
    end

`ifdef ADC_CAPTURE_DECIM_EN
    // Counts down the idle cycles between decimated captures; zero means
    // this CAPTURE cycle takes a frame.
    logic [7:0] dcnt, dcnt_nxt;
    assign cap_en = (dcnt == 8'd0);

    always_comb begin
        dcnt_nxt = 8'd0;
        if (state == ST_CAPTURE) dcnt_nxt = cap_en ? decim : dcnt - 8'd1;
    end

    always_ff @(posedge aclk) begin
        if (areset) dcnt <= 8'd0;
        else        dcnt <= dcnt_nxt;
    end
`else
    assign cap_en = 1'b1;
`endif

    assign m_axis_tvalid = !fifo_empty;
    assign pop           = m_axis_tvalid && m_axis_tready;
    assign fire          = (state == ST_CAPTURE) && !abort && cap_en;
    // A full FIFO still takes the frame when the head leaves in the same cycle.
    assign push          = fire && (!fifo_full || pop);
    assign drop          = fire && fifo_full && !pop;

    adc_capture_fifo #(
        .WIDTH (NUM_CH*LANE_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .aclk      (aclk),
        .areset    (areset),
        .push      (push),
        .push_data ({sample_counter == CNT_W'(1), frame_data}),
        .pop       (pop),
        .pop_data  (fifo_out),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign m_axis_tlast = fifo_out[NUM_CH*LANE_W];
    assign m_axis_tdata = fifo_out[NUM_CH*LANE_W-1:0];
    assign sample_state = state;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = sample_counter;
        ack_nxt   = 1'b0;
        done_nxt  = 1'b0;
        ovf_nxt   = overflow | drop;
        case (state)
            ST_IDLE: begin
                if (start_trigger) begin
                    ack_nxt = 1'b1;
                    ovf_nxt = 1'b0;
                    cnt_nxt = sample_count;
                    if (sample_count == '0) done_nxt  = 1'b1;
                    else                    state_nxt = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (abort) begin
                    state_nxt = ST_DRAIN;
                end else if (cap_en) begin
                    cnt_nxt = sample_counter - CNT_W'(1);
                    if (sample_counter == CNT_W'(1)) begin
                        if (continuous && sample_count != '0) cnt_nxt   = sample_count;
                        else                                  state_nxt = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (fifo_empty) begin
                    state_nxt = ST_IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state             <= ST_IDLE;
            sample_counter    <= '0;
            start_trigger_ack <= 1'b0;
            done              <= 1'b0;
            overflow          <= 1'b0;
        end else begin
            state             <= state_nxt;
            sample_counter    <= cnt_nxt;
            start_trigger_ack <= ack_nxt;
            done              <= done_nxt;
            overflow          <= ovf_nxt;
        end
    end

endmodule

// File: tb/tb_adc_capture_stream.sv
// tb/tb_adc_capture_stream.sv - directed self-checking bench for adc_capture_stream
module tb_adc_capture_stream;
    logic         aclk = 1'b0;
    logic         areset = 1'b1;
    logic [31:0]  sample_count = '0;
    logic         start_trigger = 1'b0;
    logic         continuous = 1'b0;
    logic         abort = 1'b0;
`ifdef ADC_CAPTURE_DECIM_EN
    logic [7:0]   decim = 8'd0;
`endif
    logic         start_trigger_ack;
    logic         done;
    logic [31:0]  sample_counter;
    logic [1:0]   sample_state;
    logic         overflow;
    logic [27:0]  adc_data = '0;
    logic [127:0] m_axis_tdata;
    logic         m_axis_tvalid;
    logic         m_axis_tlast;
    logic         m_axis_tready = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    adc_capture_stream #(
        .NUM_CH(2), .ADC_W(14), .LANE_W(64), .CNT_W(32), .FIFO_DEPTH(4), .SIGN_EXT(1)
    ) dut (
        .aclk              (aclk),
        .areset            (areset),
        .sample_count      (sample_count),
        .start_trigger     (start_trigger),
        .continuous        (continuous),
        .abort             (abort),
`ifdef ADC_CAPTURE_DECIM_EN
        .decim             (decim),
`endif
        .start_trigger_ack (start_trigger_ack),
        .done              (done),
        .sample_counter    (sample_counter),
        .sample_state      (sample_state),
        .overflow          (overflow),
        .adc_data          (adc_data),
        .m_axis_tdata      (m_axis_tdata),
        .m_axis_tvalid     (m_axis_tvalid),
        .m_axis_tlast      (m_axis_tlast),
        .m_axis_tready     (m_axis_tready)
    );

    always #5 aclk = ~aclk;

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] sx(input logic [13:0] s);
        sx = {{50{s[13]}}, s};
    endfunction

    function automatic logic [127:0] exp_frame(input logic [13:0] c1, input logic [13:0] c0);
        exp_frame = {sx(c1), sx(c0)};
    endfunction

    initial begin
        logic [13:0] c0, c1;

        // Reset state
        step(); step();
        areset = 1'b0;
        step();
        chk("rst_tvalid", 128'(m_axis_tvalid), 128'(0));
        chk("rst_state", 128'(sample_state), 128'(0));
        chk("rst_ovf", 128'(overflow), 128'(0));
        chk("rst_ack", 128'(start_trigger_ack), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        chk("rst_cnt", 128'(sample_counter), 128'(0));
        chk("rst_tdata", m_axis_tdata, 128'(0));
        chk("rst_tlast", 128'(m_axis_tlast), 128'(0));

        // Test 1: 4-frame capture, tready high, sign extension
        m_axis_tready = 1'b1;
        sample_count  = 32'd4;
        start_trigger = 1'b1;
        step();
        chk("t1_ack", 128'(start_trigger_ack), 128'(1));
        chk("t1_state", 128'(sample_state), 128'(1));
        chk("t1_cnt", 128'(sample_counter), 128'(4));
        start_trigger = 1'b0;
        for (int i = 0; i < 4; i++) begin
            c0 = 14'h1FFE + 14'(i);
            c1 = 14'h0005 + 14'(i);
            adc_data = {c1, c0};
            step();
            chk("t1_ack_low", 128'(start_trigger_ack), 128'(0));
            chk("t1_tvalid", 128'(m_axis_tvalid), 128'(1));
            chk("t1_tdata", m_axis_tdata, exp_frame(c1, c0));
            chk("t1_tlast", 128'(m_axis_tlast), 128'(i == 3));
            chk("t1_cnt_dec", 128'(sample_counter), 128'(3 - i));
            if (i == 2) chk("t1_lane0_2000", 128'(m_axis_tdata[63:0]), 128'(64'hFFFF_FFFF_FFFF_E000));
        end
        chk("t1_state_drain", 128'(sample_state), 128'(2));
        step();
        chk("t1_empty", 128'(m_axis_tvalid), 128'(0));
        chk("t1_done_early", 128'(done), 128'(0));
        step();
        chk("t1_done", 128'(done), 128'(1));
        chk("t1_idle", 128'(sample_state), 128'(0));
        step();
        chk("t1_done_pulse", 128'(done), 128'(0));

        // Zero-length capture: ack and done together, no data
        sample_count  = 32'd0;
        start_trigger = 1'b1;
        step();
        start_trigger = 1'b0;
        chk("z_ack", 128'(start_trigger_ack), 128'(1));
        chk("z_done", 128'(done), 128'(1));
        chk("z_state", 128'(sample_state), 128'(0));
        step();
        chk("z_tvalid", 128'(m_axis_tvalid), 128'(0));
        chk("z_ack_pulse", 128'(start_trigger_ack), 128'(0));

        // Test 2: overflow with tready held low, depth 4
        m_axis_tready = 1'b0;
        sample_count  = 32'd8;
        start_trigger = 1'b1;
        step();
        start_trigger = 1'b0;
        chk("t2_ack", 128'(start_trigger_ack), 128'(1));
        for (int j = 0; j < 8; j++) begin
            adc_data = {14'h3F00 + 14'(j), 14'h0100 + 14'(j)};
            step();
            if (j == 3) chk("t2_ovf_before", 128'(overflow), 128'(0));
            if (j == 4) chk("t2_ovf_set", 128'(overflow), 128'(1));
        end
        chk("t2_state_drain", 128'(sample_state), 128'(2));
        for (int j = 0; j < 11; j++) begin
            step();
            chk("t2_hold_tvalid", 128'(m_axis_tvalid), 128'(1));
            chk("t2_hold_tdata", m_axis_tdata, exp_frame(14'h3F00, 14'h0100));
        end
        m_axis_tready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            chk("t2_tvalid", 128'(m_axis_tvalid), 128'(1));
            chk("t2_tdata", m_axis_tdata, exp_frame(14'h3F00 + 14'(j), 14'h0100 + 14'(j)));
            chk("t2_no_tlast", 128'(m_axis_tlast), 128'(0));
            step();
        end
        chk("t2_drained", 128'(m_axis_tvalid), 128'(0));
        step();
        chk("t2_done", 128'(done), 128'(1));
        chk("t2_idle", 128'(sample_state), 128'(0));
        chk("t2_ovf_sticky", 128'(overflow), 128'(1));

        // Test 3: continuous, 3 blocks of 3, one ack
        continuous    = 1'b1;
        sample_count  = 32'd3;
        start_trigger = 1'b1;
        step();
        start_trigger = 1'b0;
        chk("t3_ack", 128'(start_trigger_ack), 128'(1));
        chk("t3_ovf_clr", 128'(overflow), 128'(0));
        for (int k = 0; k < 9; k++) begin
            if (k == 6) continuous = 1'b0;
            adc_data = {14'h1000 + 14'(k), 14'h00A0 + 14'(k)};
            step();
            chk("t3_ack_once", 128'(start_trigger_ack), 128'(0));
            chk("t3_tvalid", 128'(m_axis_tvalid), 128'(1));
            chk("t3_tdata", m_axis_tdata, exp_frame(14'h1000 + 14'(k), 14'h00A0 + 14'(k)));
            chk("t3_tlast", 128'(m_axis_tlast), 128'(k % 3 == 2));
            chk("t3_cnt", 128'(sample_counter), 128'((k == 8) ? 0 : 3 - ((k + 1) % 3)));
        end
        chk("t3_drain", 128'(sample_state), 128'(2));
        step();
        chk("t3_empty", 128'(m_axis_tvalid), 128'(0));
        step();
        chk("t3_done", 128'(done), 128'(1));

        // Test 4: abort on third CAPTURE cycle; trigger in DRAIN ignored
        sample_count  = 32'd10;
        start_trigger = 1'b1;
        step();
        start_trigger = 1'b0;
        chk("t4_ack", 128'(start_trigger_ack), 128'(1));
        for (int k = 0; k < 2; k++) begin
            adc_data = {14'h0222 + 14'(k), 14'h0111 + 14'(k)};
            step();
            chk("t4_tdata", m_axis_tdata, exp_frame(14'h0222 + 14'(k), 14'h0111 + 14'(k)));
            chk("t4_no_tlast", 128'(m_axis_tlast), 128'(0));
        end
        abort    = 1'b1;
        adc_data = {14'h0EEE, 14'h0DDD};
        step();
        abort = 1'b0;
        chk("t4_abort_nocap", 128'(m_axis_tvalid), 128'(0));
        chk("t4_state_drain", 128'(sample_state), 128'(2));
        chk("t4_cnt_hold", 128'(sample_counter), 128'(8));
        start_trigger = 1'b1;
        step();
        start_trigger = 1'b0;
        chk("t4_no_ack_drain", 128'(start_trigger_ack), 128'(0));
        chk("t4_done", 128'(done), 128'(1));
        chk("t4_idle", 128'(sample_state), 128'(0));

        // Test 5: reset with frames queued and overflow set
        m_axis_tready = 1'b0;
        sample_count  = 32'd5;
        start_trigger = 1'b1;
        step();
        start_trigger = 1'b0;
        for (int k = 0; k < 5; k++) begin
            adc_data = {14'h0300 + 14'(k), 14'h0030 + 14'(k)};
            step();
        end
        chk("t5_ovf", 128'(overflow), 128'(1));
        m_axis_tready = 1'b1;
        step();
        m_axis_tready = 1'b0;
        chk("t5_queued", 128'(m_axis_tvalid), 128'(1));
        areset = 1'b1;
        step();
        areset = 1'b0;
        chk("t5_tvalid", 128'(m_axis_tvalid), 128'(0));
        chk("t5_state", 128'(sample_state), 128'(0));
        chk("t5_ovf_clr", 128'(overflow), 128'(0));
        chk("t5_tdata", m_axis_tdata, 128'(0));
        m_axis_tready = 1'b1;
        sample_count  = 32'd2;
        start_trigger = 1'b1;
        step();
        start_trigger = 1'b0;
        chk("t5_ack", 128'(start_trigger_ack), 128'(1));
        for (int k = 0; k < 2; k++) begin
            adc_data = {14'h2AAA - 14'(k), 14'h1555 + 14'(k)};
            step();
            chk("t5_tdata2", m_axis_tdata, exp_frame(14'h2AAA - 14'(k), 14'h1555 + 14'(k)));
            chk("t5_tlast", 128'(m_axis_tlast), 128'(k == 1));
        end
        step();
        step();
        chk("t5_done", 128'(done), 128'(1));

`ifdef ADC_CAPTURE_DECIM_EN
        // Test 6: decimation by 3
        decim         = 8'd2;
        sample_count  = 32'd3;
        start_trigger = 1'b1;
        step();
        start_trigger = 1'b0;
        chk("t6_ack", 128'(start_trigger_ack), 128'(1));
        for (int c = 0; c < 7; c++) begin
            c0 = 14'h0050 + 14'(c);
            c1 = 14'h3FF0 - 14'(c);
            adc_data = {c1, c0};
            step();
            chk("t6_tvalid", 128'(m_axis_tvalid), 128'(c % 3 == 0));
            if (c % 3 == 0) begin
                chk("t6_tdata", m_axis_tdata, exp_frame(c1, c0));
                chk("t6_tlast", 128'(m_axis_tlast), 128'(c == 6));
            end
            chk("t6_cnt", 128'(sample_counter), 128'(3 - (c / 3 + 1)));
        end
        step();
        step();
        chk("t6_done", 128'(done), 128'(1));
        decim = 8'd0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
